// File: rtl/demux2b16_slot_pkg.sv
//------------------------------------------------------------------------------
// Module   : demux2b16_slot_pkg
// Brief    : Shared select encoding and defaults for the 1:4 write-side router.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux2b16_slot_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int NUM_SLOTS     = 4;
   localparam int CNT_WIDTH     = 8;

   // Same encoding as the 4:1 source mux on the read side.
   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

   function automatic logic [NUM_SLOTS-1:0] op_decode(input logic [1:0] op);
      logic [NUM_SLOTS-1:0] onehot;
      onehot = '0;
      case (op)
         SEL_A:   onehot[0] = 1'b1;
         SEL_B:   onehot[1] = 1'b1;
         SEL_C:   onehot[2] = 1'b1;
         default: onehot[3] = 1'b1;
      endcase
      return onehot;
   endfunction

endpackage : demux2b16_slot_pkg

`default_nettype wire

// File: rtl/demux2b16_slot_slot.sv
//------------------------------------------------------------------------------
// Module   : demux_slot
// Brief    : One-entry holding register with load/drain handshake and, when
//            DEMUX2B16_SLOT_CNT_EN is defined, an 8-bit wrapping drain counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_slot
   import demux2b16_slot_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic [WIDTH-1:0]     i_data,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [WIDTH-1:0]     o_data
`ifdef DEMUX2B16_SLOT_CNT_EN
   ,
   input  logic                 i_cnt_clr,
   output logic [CNT_WIDTH-1:0] o_cnt
`endif
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_drain;

   // Ready on an empty slot is meaningless and must not count as a drain.
   assign w_drain = r_valid & i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

`ifdef DEMUX2B16_SLOT_CNT_EN
   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_drain) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
`endif

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux2b16_slot.sv
//------------------------------------------------------------------------------
// Module   : demux2b16_slot
// Brief    : 1:4 write-side router; one valid/ready input routed by OP into four
//            one-entry output slots. Optional macro DEMUX2B16_SLOT_CNT_EN adds
//            per-slot drain counters and CntClr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux2b16_slot
   import demux2b16_slot_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [WIDTH-1:0]     In,
   input  logic [1:0]           OP,
   input  logic                 InValid,
   output logic                 InReady,
   output logic [WIDTH-1:0]     OutA,
   output logic [WIDTH-1:0]     OutB,
   output logic [WIDTH-1:0]     OutC,
   output logic [WIDTH-1:0]     OutD,
   output logic                 ValidA,
   output logic                 ValidB,
   output logic                 ValidC,
   output logic                 ValidD,
   input  logic                 ReadyA,
   input  logic                 ReadyB,
   input  logic                 ReadyC,
   input  logic                 ReadyD
`ifdef DEMUX2B16_SLOT_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] CntA,
   output logic [CNT_WIDTH-1:0] CntB,
   output logic [CNT_WIDTH-1:0] CntC,
   output logic [CNT_WIDTH-1:0] CntD,
   input  logic                 CntClr
`endif
);

   logic [NUM_SLOTS-1:0] w_sel;
   logic [NUM_SLOTS-1:0] w_load;
   logic [NUM_SLOTS-1:0] w_valid;
   logic [NUM_SLOTS-1:0] w_ready;
   logic [WIDTH-1:0]     w_data [NUM_SLOTS];
   logic                 w_accept;

   assign w_sel   = op_decode(OP);
   assign w_ready = {ReadyD, ReadyC, ReadyB, ReadyA};

   // A full slot can still accept when its consumer drains it in the same edge.
   assign InReady  = RST_N & (~w_valid[OP] | w_ready[OP]);
   assign w_accept = InValid & InReady;
   assign w_load   = w_sel & {NUM_SLOTS{w_accept}};

`ifdef DEMUX2B16_SLOT_CNT_EN
   logic [CNT_WIDTH-1:0] w_cnt [NUM_SLOTS];
`endif

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      demux_slot #(
         .WIDTH     (WIDTH)
      ) u_slot (
         .clk       (CLK),
         .rst_n     (RST_N),
         .i_load    (w_load[gi]),
         .i_data    (In),
         .i_ready   (w_ready[gi]),
         .o_valid   (w_valid[gi]),
         .o_data    (w_data[gi])
`ifdef DEMUX2B16_SLOT_CNT_EN
         ,
         .i_cnt_clr (CntClr),
         .o_cnt     (w_cnt[gi])
`endif
      );
   end

   assign OutA   = w_data[0];
   assign OutB   = w_data[1];
   assign OutC   = w_data[2];
   assign OutD   = w_data[3];
   assign ValidA = w_valid[0];
   assign ValidB = w_valid[1];
   assign ValidC = w_valid[2];
   assign ValidD = w_valid[3];

`ifdef DEMUX2B16_SLOT_CNT_EN
   assign CntA = w_cnt[0];
   assign CntB = w_cnt[1];
   assign CntC = w_cnt[2];
   assign CntD = w_cnt[3];
`endif

endmodule : demux2b16_slot

`default_nettype wire

// File: tb/tb_demux2b16_slot.sv
//------------------------------------------------------------------------------
// Module   : tb_demux2b16_slot
// Brief    : Directed self-checking bench for demux2b16_slot (counter checks
//            enabled when DEMUX2B16_SLOT_CNT_EN is defined).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux2b16_slot;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] In;
   logic [1:0]  OP;
   logic        InValid;
   logic        InReady;
   logic [15:0] OutA, OutB, OutC, OutD;
   logic        ValidA, ValidB, ValidC, ValidD;
   logic        ReadyA, ReadyB, ReadyC, ReadyD;
`ifdef DEMUX2B16_SLOT_CNT_EN
   logic [7:0]  CntA, CntB, CntC, CntD;
   logic        CntClr;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   demux2b16_slot #(.WIDTH(16)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .In      (In),
      .OP      (OP),
      .InValid (InValid),
      .InReady (InReady),
      .OutA    (OutA),
      .OutB    (OutB),
      .OutC    (OutC),
      .OutD    (OutD),
      .ValidA  (ValidA),
      .ValidB  (ValidB),
      .ValidC  (ValidC),
      .ValidD  (ValidD),
      .ReadyA  (ReadyA),
      .ReadyB  (ReadyB),
      .ReadyC  (ReadyC),
      .ReadyD  (ReadyD)
`ifdef DEMUX2B16_SLOT_CNT_EN
      ,
      .CntA    (CntA),
      .CntB    (CntB),
      .CntC    (CntC),
      .CntD    (CntD),
      .CntClr  (CntClr)
`endif
   );

   // Advance one rising edge; inputs are changed and outputs sampled 1 ns later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      InValid = 1'b0;
      In      = 16'h0000;
      OP      = 2'b00;
      {ReadyA, ReadyB, ReadyC, ReadyD} = 4'b0000;
   endtask

   task automatic test_reset();
      RST_N   = 1'b0;
      idle_inputs();
      InValid = 1'b1;
      In      = 16'hAAAA;
`ifdef DEMUX2B16_SLOT_CNT_EN
      CntClr  = 1'b0;
`endif
      step(); step(); step();
      n_chk++;
      if ({ValidA, ValidB, ValidC, ValidD} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_valid got=%b want=0000", {ValidA, ValidB, ValidC, ValidD});
      end
      n_chk++;
      if ({OutA, OutB, OutC, OutD} !== 64'h0) begin
         n_bad++; $display("FAIL reset_out got=%h want=0", {OutA, OutB, OutC, OutD});
      end
      n_chk++;
      if (InReady !== 1'b0) begin
         n_bad++; $display("FAIL reset_inready got=%b want=0", InReady);
      end
      InValid = 1'b0;
      RST_N   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         OP = 2'(i);
         #1;
         n_chk++;
         if (InReady !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_inready op=%0d got=%b want=1", i, InReady);
         end
      end
      OP = 2'b00;
   endtask

   task automatic test_routing();
      logic [15:0] words [4];
      logic [15:0] got;
      logic        gv;
      words[0] = 16'h0008; words[1] = 16'h0004;
      words[2] = 16'h0002; words[3] = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         In = words[i]; OP = 2'(i); InValid = 1'b1;
         #1;
         n_chk++;
         if (InReady !== 1'b1) begin
            n_bad++; $display("FAIL route_inready op=%0d got=%b want=1", i, InReady);
         end
         step();
         case (i)
            0: begin got = OutA; gv = ValidA; end
            1: begin got = OutB; gv = ValidB; end
            2: begin got = OutC; gv = ValidC; end
            default: begin got = OutD; gv = ValidD; end
         endcase
         n_chk++;
         if (got !== words[i] || gv !== 1'b1) begin
            n_bad++; $display("FAIL route_slot%0d got=%h/%b want=%h/1", i, got, gv, words[i]);
         end
      end
      InValid = 1'b0;
      step();
      n_chk++;
      if ({OutA, OutB, OutC, OutD} !== 64'h0008_0004_0002_0001 ||
          {ValidA, ValidB, ValidC, ValidD} !== 4'b1111) begin
         n_bad++; $display("FAIL route_all got=%h/%b want=0008000400020001/1111",
                           {OutA, OutB, OutC, OutD}, {ValidA, ValidB, ValidC, ValidD});
      end
   endtask

   task automatic test_backpressure();
      In = 16'h00FF; OP = 2'b10; InValid = 1'b1; ReadyC = 1'b0;
      #1;
      n_chk++;
      if (InReady !== 1'b0) begin
         n_bad++; $display("FAIL bp_inready_c got=%b want=0", InReady);
      end
      step();
      n_chk++;
      if (OutC !== 16'h0002 || ValidC !== 1'b1) begin
         n_bad++; $display("FAIL bp_hold_c got=%h/%b want=0002/1", OutC, ValidC);
      end
      // Slot A is also full, so its consumer drains while the new word refills it.
      In = 16'h1234; OP = 2'b00; ReadyA = 1'b1;
      #1;
      n_chk++;
      if (InReady !== 1'b1) begin
         n_bad++; $display("FAIL bp_inready_a got=%b want=1", InReady);
      end
      step();
      InValid = 1'b0; ReadyA = 1'b0;
      n_chk++;
      if (OutA !== 16'h1234 || ValidA !== 1'b1 || OutC !== 16'h0002) begin
         n_bad++; $display("FAIL bp_accept_a got=%h/%b c=%h want=1234/1 c=0002", OutA, ValidA, OutC);
      end
   endtask

   task automatic test_drain_refill();
      In = 16'h00FF; OP = 2'b10; InValid = 1'b1; ReadyC = 1'b1;
      #1;
      n_chk++;
      if (InReady !== 1'b1) begin
         n_bad++; $display("FAIL refill_inready got=%b want=1", InReady);
      end
      step();
      InValid = 1'b0; ReadyC = 1'b0;
      n_chk++;
      if (OutC !== 16'h00FF || ValidC !== 1'b1) begin
         n_bad++; $display("FAIL refill_c got=%h/%b want=00ff/1", OutC, ValidC);
      end
   endtask

   task automatic test_empty_ready();
      ReadyD = 1'b1;
      step();
      n_chk++;
      if (ValidD !== 1'b0 || OutD !== 16'h0001) begin
         n_bad++; $display("FAIL drain_d got=%h/%b want=0001/0", OutD, ValidD);
      end
      step();
      n_chk++;
      if (ValidD !== 1'b0 || OutD !== 16'h0001 || ValidC !== 1'b1) begin
         n_bad++; $display("FAIL empty_ready_d got=%h/%b c=%b want=0001/0 c=1", OutD, ValidD, ValidC);
      end
      ReadyD = 1'b0;
   endtask

   task automatic test_stream();
      int drains = 0;
      ReadyD = 1'b1; OP = 2'b11;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            In = 16'h0010 + 16'(i); InValid = 1'b1;
         end else begin
            InValid = 1'b0;
         end
         #1;
         if (i > 0) begin
            n_chk++;
            if (ValidD !== 1'b1 || OutD !== 16'h0010 + 16'(i - 1)) begin
               n_bad++; $display("FAIL stream_word%0d got=%h/%b want=%h/1", i - 1, OutD, ValidD, 16'h0010 + 16'(i - 1));
            end else begin
               drains++;
            end
         end
         if (i < 8) begin
            n_chk++;
            if (InReady !== 1'b1) begin
               n_bad++; $display("FAIL stream_inready%0d got=%b want=1", i, InReady);
            end
         end
         step();
      end
      n_chk++;
      if (drains != 8 || ValidD !== 1'b0) begin
         n_bad++; $display("FAIL stream_count got=%0d/%b want=8/0", drains, ValidD);
      end
      ReadyD = 1'b0;
   endtask

   task automatic test_reset_mid();
      In = 16'hBEEF; OP = 2'b01; InValid = 1'b1; ReadyB = 1'b1;
      #2;
      RST_N = 1'b0;
      #1;
      n_chk++;
      if ({ValidA, ValidB, ValidC, ValidD} !== 4'b0000 || {OutA, OutB, OutC, OutD} !== 64'h0 ||
          InReady !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid got=%b/%h/%b want=0000/0/0",
                           {ValidA, ValidB, ValidC, ValidD}, {OutA, OutB, OutC, OutD}, InReady);
      end
      idle_inputs();
      step();
      RST_N = 1'b1;
      step();
      n_chk++;
      if ({ValidA, ValidB, ValidC, ValidD} !== 4'b0000 || OutB !== 16'h0000) begin
         n_bad++; $display("FAIL reset_mid_after got=%b/%h want=0000/0", {ValidA, ValidB, ValidC, ValidD}, OutB);
      end
   endtask

`ifdef DEMUX2B16_SLOT_CNT_EN
   task automatic test_counters();
      RST_N = 1'b0; idle_inputs(); CntClr = 1'b0;
      step();
      RST_N = 1'b1;
      ReadyB = 1'b1; OP = 2'b01;
      for (int i = 0; i < 257; i++) begin
         InValid = (i < 256); In = 16'(i);
         step();
      end
      n_chk++;
      if (CntB !== 8'd0 || CntA !== 8'd0 || ValidB !== 1'b0) begin
         n_bad++; $display("FAIL cnt_wrap got=%0d a=%0d v=%b want=0 a=0 v=0", CntB, CntA, ValidB);
      end
      for (int i = 0; i < 4; i++) begin
         InValid = (i < 3);
         step();
      end
      n_chk++;
      if (CntB !== 8'd3) begin
         n_bad++; $display("FAIL cnt_three got=%0d want=3", CntB);
      end
      InValid = 1'b1;
      step();
      InValid = 1'b0; CntClr = 1'b1;
      step();
      CntClr = 1'b0;
      n_chk++;
      if (CntB !== 8'd0 || ValidB !== 1'b0) begin
         n_bad++; $display("FAIL cnt_clr got=%0d/%b want=0/0", CntB, ValidB);
      end
      OP = 2'b00; ReadyA = 1'b1; InValid = 1'b1;
      step();
      OP = 2'b01;
      step();
      InValid = 1'b0;
      step();
      n_chk++;
      if (CntA !== 8'd1 || CntB !== 8'd1) begin
         n_bad++; $display("FAIL cnt_pre_rst got=%0d/%0d want=1/1", CntA, CntB);
      end
      RST_N = 1'b0;
      #1;
      RST_N = 1'b1;
      #1;
      n_chk++;
      if ({CntA, CntB, CntC, CntD} !== 32'h0) begin
         n_bad++; $display("FAIL cnt_rst got=%h want=0", {CntA, CntB, CntC, CntD});
      end
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_drain_refill();
      test_empty_ready();
      test_stream();
      test_reset_mid();
`ifdef DEMUX2B16_SLOT_CNT_EN
      test_counters();
`endif
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_demux2b16_slot

`default_nettype wire
